// File: rtl/plab2_proc_imul_arbiter.sv
// Round-robin arbiter that shares one variable-latency multiplier among several cores.
// Only one transaction is in flight at a time, and the response goes back only to the core that owns it.
module plab2_proc_imul_arbiter #(
   parameter int p_num_cores = 4,
   parameter int p_msg_nbits = 67
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [p_num_cores-1:0]             req_val,
   output logic [p_num_cores-1:0]             req_rdy,
   input  logic [p_num_cores*p_msg_nbits-1:0] req_msg,
   input  logic [p_num_cores-1:0]             req_domain,
   output logic [p_num_cores-1:0]             resp_val,
   input  logic [p_num_cores-1:0]             resp_rdy,
   output logic [p_num_cores*32-1:0]          resp_msg,
   output logic                               unit_req_val,
   input  logic                               unit_req_rdy,
   output logic [p_msg_nbits-1:0]             unit_req_msg,
   input  logic                               unit_resp_val,
   output logic                               unit_resp_rdy,
   input  logic [31:0]                        unit_resp_msg,
   output logic                               unit_domain,
   output logic [31:0]                        busy_cycles
);

   // state   | meaning
   // ST_IDLE | no transaction in flight; arbitrate among requesters
   // ST_WAIT | one transaction owned by owner_q; waiting for its response

   localparam int IDX_W = (p_num_cores > 1) ? $clog2(p_num_cores) : 1;
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_WAIT = 1'b1;

   logic [0:0]       state_q;
   logic [IDX_W-1:0] owner_q;
   logic             owner_dom_q;
   logic [IDX_W-1:0] prio_q;
   logic [31:0]      busy_q;

   logic [IDX_W-1:0] winner;
   logic [IDX_W-1:0] next_prio;
   logic             any_req;
   logic             run;
   logic             in_idle;
   logic             in_wait;
   logic             req_fire;
   logic             resp_fire;
   int               scan_idx;

   assign run     = reset;
   assign any_req = |req_val;
   assign in_idle = run && (state_q == ST_IDLE);
   assign in_wait = run && (state_q == ST_WAIT);

   // Search starts at prio_q and wraps, so the core just served has the lowest priority.
   always_comb begin
      winner   = '0;
      scan_idx = 0;
      for (int k = p_num_cores - 1; k >= 0; k--) begin
         scan_idx = (int'(prio_q) + k) % p_num_cores;
         if (req_val[scan_idx]) winner = IDX_W'(scan_idx);
      end
   end

   assign next_prio = (int'(owner_q) == p_num_cores - 1) ? '0 : owner_q + 1'b1;

   always_comb begin
      req_rdy       = '0;
      resp_val      = '0;
      resp_msg      = '0;
      unit_req_val  = 1'b0;
      unit_req_msg  = '0;
      unit_resp_rdy = 1'b0;
      unit_domain   = 1'b0;
      if (in_idle && any_req) begin
         unit_req_val    = 1'b1;
         unit_req_msg    = req_msg[winner*p_msg_nbits +: p_msg_nbits];
         unit_domain     = req_domain[winner];
         req_rdy[winner] = unit_req_rdy;
      end else if (in_wait) begin
         unit_domain                 = owner_dom_q;
         resp_val[owner_q]           = unit_resp_val;
         resp_msg[owner_q*32 +: 32]  = unit_resp_msg;
         unit_resp_rdy               = resp_rdy[owner_q];
      end
   end

   assign req_fire  = unit_req_val && unit_req_rdy;
   assign resp_fire = in_wait && unit_resp_val && unit_resp_rdy;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         owner_q     <= '0;
         owner_dom_q <= 1'b0;
         prio_q      <= '0;
         busy_q      <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_fire) begin
                  state_q     <= ST_WAIT;
                  owner_q     <= winner;
                  owner_dom_q <= req_domain[winner];
               end
            end
            default: begin
               if (busy_q != 32'hFFFF_FFFF) busy_q <= busy_q + 32'd1;
               if (resp_fire) begin
                  state_q <= ST_IDLE;
                  prio_q  <= next_prio;
               end
            end
         endcase
      end
   end

   assign busy_cycles = busy_q;

endmodule

// File: tb/tb_plab2_proc_imul_arbiter.sv
// Directed bench for the multiplier arbiter: it uses a behavioural multiplier and a response scoreboard.
module tb_plab2_proc_imul_arbiter;
   localparam int N = 4;
   localparam int W = 67;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic [N-1:0]     req_val = '0;
   logic [N-1:0]     req_rdy;
   logic [N*W-1:0]   req_msg = '0;
   logic [N-1:0]     req_domain = '0;
   logic [N-1:0]     resp_val;
   logic [N-1:0]     resp_rdy = '1;
   logic [N*32-1:0]  resp_msg;
   logic             unit_req_val;
   logic             unit_req_rdy;
   logic [W-1:0]     unit_req_msg;
   logic             unit_resp_val;
   logic             unit_resp_rdy;
   logic [31:0]      unit_resp_msg;
   logic             unit_domain;
   logic [31:0]      busy_cycles;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int          core;
      logic [31:0] prod;
   } exp_t;
   exp_t sb[$];
   exp_t mon_e;

   int          lat = 4;
   logic        mbusy = 1'b0;
   int          mcnt = 0;
   logic [31:0] mprod = '0;

   plab2_proc_imul_arbiter #(.p_num_cores(N), .p_msg_nbits(W)) dut (
      .clk(clk), .reset(reset),
      .req_val(req_val), .req_rdy(req_rdy), .req_msg(req_msg), .req_domain(req_domain),
      .resp_val(resp_val), .resp_rdy(resp_rdy), .resp_msg(resp_msg),
      .unit_req_val(unit_req_val), .unit_req_rdy(unit_req_rdy), .unit_req_msg(unit_req_msg),
      .unit_resp_val(unit_resp_val), .unit_resp_rdy(unit_resp_rdy), .unit_resp_msg(unit_resp_msg),
      .unit_domain(unit_domain), .busy_cycles(busy_cycles)
   );

   always #5 clk = ~clk;

   // Behavioural multiplier: after accepting a request it waits lat cycles, then holds out_val until out_rdy is seen.
   assign unit_req_rdy  = !mbusy;
   assign unit_resp_val = mbusy && (mcnt == 0);
   assign unit_resp_msg = unit_resp_val ? mprod : 32'h0;

   always @(posedge clk) begin
      if (!reset) begin
         mbusy <= 1'b0;
         mcnt  <= 0;
         mprod <= '0;
      end else if (!mbusy) begin
         if (unit_req_val) begin
            mbusy <= 1'b1;
            mcnt  <= lat;
            mprod <= unit_req_msg[63:32] * unit_req_msg[31:0];
         end
      end else if (mcnt != 0) begin
         mcnt <= mcnt - 1;
      end else if (unit_resp_rdy) begin
         mbusy <= 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if ((resp_val & resp_rdy) != '0) begin
         if (sb.size() == 0) begin
            chk("resp_unexpected", 128'(resp_val), 128'(0));
         end else begin
            mon_e = sb.pop_front();
            chk($sformatf("resp_val_core%0d", mon_e.core), 128'(resp_val), 128'(1) << mon_e.core);
            chk($sformatf("resp_msg_core%0d", mon_e.core), resp_msg, {96'b0, mon_e.prod} << (32 * mon_e.core));
         end
      end
   end

   task automatic set_msg(input int core, input logic [31:0] a, input logic [31:0] b);
      req_msg[core*W +: W] = {3'b000, a, b};
   endtask

   task automatic wait_grant(input int core, input logic dom);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 50 && !seen; c++) begin
         @(negedge clk);
         if (unit_req_val && unit_req_rdy) begin
            seen = 1'b1;
            chk($sformatf("grant_core%0d", core), 128'(req_rdy), 128'(1) << core);
            chk($sformatf("grant_dom_core%0d", core), 128'(unit_domain), 128'(dom));
         end
      end
      if (!seen) chk("grant_timeout", 128'(seen), 128'(1));
      @(posedge clk);
      #1;
   endtask

   task automatic wait_empty();
      for (int c = 0; c < 200; c++) begin
         @(posedge clk);
         #2;
         if (sb.size() == 0) break;
      end
      chk("sb_drain", 128'(sb.size()), 128'(0));
   endtask

   initial begin
      int order [5];
      int g;
      int cyc;
      int fire_cyc;
      order = '{0, 1, 2, 3, 0};

      // Reset cycle: outputs must stay quiet even with every core requesting.
      reset      = 1'b0;
      req_val    = 4'hF;
      req_domain = 4'hF;
      @(posedge clk);
      @(negedge clk);
      chk("rst_req_rdy", 128'(req_rdy), 128'(0));
      chk("rst_resp_val", 128'(resp_val), 128'(0));
      chk("rst_unit_req_val", 128'(unit_req_val), 128'(0));
      chk("rst_unit_resp_rdy", 128'(unit_resp_rdy), 128'(0));
      chk("rst_unit_domain", 128'(unit_domain), 128'(0));
      chk("rst_busy", 128'(busy_cycles), 128'(0));
      @(posedge clk);
      #1;
      reset      = 1'b1;
      req_val    = '0;
      req_domain = '0;

      // Single core: core2 computes 3*5 with latency 4.
      lat = 4;
      set_msg(2, 32'd3, 32'd5);
      req_val = 4'b0100;
      sb.push_back('{2, 32'd15});
      wait_grant(2, 1'b0);
      req_val = '0;
      wait_empty();
      chk("single_busy", 128'(busy_cycles), 128'(5));

      // Contention from reset: every core requests continuously.
      @(posedge clk);
      #1 reset = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      lat = 2;
      for (int i = 0; i < N; i++) set_msg(i, 32'(i + 1), 32'd10);
      for (int i = 0; i < 5; i++) sb.push_back('{order[i], 32'((order[i] + 1) * 10)});
      req_val  = 4'hF;
      g        = 0;
      cyc      = 0;
      fire_cyc = -10;
      for (int c = 0; c < 300 && g < 5; c++) begin
         @(negedge clk);
         cyc++;
         if (unit_resp_val && unit_resp_rdy) fire_cyc = cyc;
         if (unit_req_val && unit_req_rdy) begin
            chk($sformatf("rr_grant%0d", g), 128'(req_rdy), 128'(1) << order[g]);
            if (g > 0) chk($sformatf("rr_bubble%0d", g), 128'(cyc), 128'(fire_cyc + 1));
            g++;
         end
      end
      chk("rr_grant_count", 128'(g), 128'(5));
      @(posedge clk);
      #1 req_val = '0;
      wait_empty();

      // Backpressure: core1 holds off its response for 6 cycles.
      lat = 1;
      set_msg(1, 32'd6, 32'd11);
      sb.push_back('{1, 32'h0000_0042});
      resp_rdy = 4'b1101;
      req_val  = 4'b0010;
      wait_grant(1, 1'b0);
      req_val = '0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (unit_resp_val) break;
      end
      chk("bp_resp_seen", 128'(unit_resp_val), 128'(1));
      for (int k = 0; k < 6; k++) begin
         if (k > 0) @(negedge clk);
         chk("bp_unit_resp_rdy", 128'(unit_resp_rdy), 128'(0));
         chk("bp_resp_val", 128'(resp_val), 128'(4'b0010));
         chk("bp_resp_msg1", 128'(resp_msg[63:32]), 128'(32'h42));
      end
      @(posedge clk);
      #1 resp_rdy = 4'hF;
      wait_empty();

      // Advance the priority pointer to 3 with a core2 transaction.
      set_msg(2, 32'd7, 32'd7);
      sb.push_back('{2, 32'd49});
      req_val = 4'b0100;
      wait_grant(2, 1'b0);
      req_val = '0;
      wait_empty();

      // Domain isolation: core3 (domain 0) then core0 (domain 1).
      lat = 3;
      set_msg(0, 32'd2, 32'd9);
      set_msg(3, 32'd4, 32'd4);
      req_domain = 4'b0001;
      sb.push_back('{3, 32'd16});
      sb.push_back('{0, 32'd18});
      req_val = 4'b1001;
      wait_grant(3, 1'b0);
      req_val = 4'b0001;
      @(negedge clk);
      chk("dom_wait_core3", 128'(unit_domain), 128'(0));
      wait_grant(0, 1'b1);
      req_val = '0;
      @(negedge clk);
      chk("dom_wait_core0", 128'(unit_domain), 128'(1));
      chk("dom_resp_msg3_iso", 128'(resp_msg[127:96]), 128'(0));
      wait_empty();
      req_domain = '0;

      // Reset mid-transaction: the pointer (now 1) must return to 0.
      lat = 10;
      set_msg(3, 32'd5, 32'd5);
      sb.push_back('{3, 32'd25});
      req_val = 4'b1000;
      wait_grant(3, 1'b0);
      req_val = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      sb.delete();
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("midrst_busy", 128'(busy_cycles), 128'(0));
      chk("midrst_resp_val", 128'(resp_val), 128'(0));
      chk("midrst_unit_resp_rdy", 128'(unit_resp_rdy), 128'(0));
      @(posedge clk);
      #1;
      lat = 2;
      set_msg(0, 32'd8, 32'd3);
      sb.push_back('{0, 32'd24});
      req_val = 4'b1001;
      wait_grant(0, 1'b0);
      req_val = '0;
      wait_empty();

      // Saturation: preload the counter near its maximum, then spend 3 cycles in WAIT.
      @(negedge clk);
      force dut.busy_q = 32'hFFFF_FFFE;
      @(negedge clk);
      release dut.busy_q;
      @(posedge clk);
      #1;
      lat = 6;
      set_msg(2, 32'd1, 32'd1);
      sb.push_back('{2, 32'd1});
      req_val = 4'b0100;
      wait_grant(2, 1'b0);
      req_val = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("sat_busy", 128'(busy_cycles), 128'(32'hFFFF_FFFF));
      wait_empty();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
